vga_frame_reader: RTL and testbench

//  Read-side master of the single-port-read frame buffer: scans the 640x480 cell RAM in raster order and

---
 rtl/vga_frame_reader.sv | 129 ++++++++++++
 tb/tb_vga_frame_reader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Raster-scan reader for the cell frame buffer: drives the read address, maps each
// cell code through the palette and produces VGA sync/blank timing aligned with the RGB.
module vga_frame_reader #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4,
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic [11:0]           rgb_o,
   output logic                  vblank_o
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = $clog2(CLK_DIV);

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END   = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END   = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_VIS_LAST  = VW'(V_VISIBLE - 1);
   localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);

   logic [DW-1:0]         div_r;
   logic [HW-1:0]         hcnt_r;
   logic [VW-1:0]         vcnt_r;
   logic [ADDR_WIDTH-1:0] pix_r;
   logic                  act_d_r;
   logic                  hs_d_r;
   logic                  vs_d_r;

   logic tick_s;
   logic active_s;
   logic hsync_s;
   logic vsync_s;
   logic h_wrap_s;
   logic frame_end_s;

   function automatic logic [11:0] pal(input logic [DATA_WIDTH-1:0] code);
      logic [11:0] rgb;
      case (code)
         DATA_WIDTH'(32'd0): rgb = 12'h000;
         DATA_WIDTH'(32'd1): rgb = 12'hDB6;
         DATA_WIDTH'(32'd2): rgb = 12'h888;
         DATA_WIDTH'(32'd3): rgb = 12'h04F;
         default:            rgb = 12'hF0F;
      endcase
      return rgb;
   endfunction

   // Decode of the current scan position
   always_comb begin
      tick_s      = (div_r == DIV_LAST);
      active_s    = (hcnt_r < H_VIS_END) && (vcnt_r < V_VIS_END);
      hsync_s     = !((hcnt_r >= H_SYNC_BEG) && (hcnt_r <= H_SYNC_LAST));
      vsync_s     = !((vcnt_r >= V_SYNC_BEG) && (vcnt_r <= V_SYNC_LAST));
      h_wrap_s    = (hcnt_r == H_LAST);
      frame_end_s = h_wrap_s && (vcnt_r == V_LAST);
   end

   // Pixel divider, raster counters and the two-tick output pipeline
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_r     <= '0;
         hcnt_r    <= '0;
         vcnt_r    <= '0;
         pix_r     <= '0;
         act_d_r   <= 1'b0;
         hs_d_r    <= 1'b1;
         vs_d_r    <= 1'b1;
         rd_addr_o <= '0;
         rgb_o     <= 12'h000;
         hsync_o   <= 1'b1;
         vsync_o   <= 1'b1;
         vblank_o  <= 1'b0;
      end else begin
         vblank_o <= 1'b0;
         if (tick_s) begin
            div_r  <= '0;
            hcnt_r <= h_wrap_s ? '0 : hcnt_r + HW'(1);
            if (h_wrap_s) begin
               vcnt_r <= (vcnt_r == V_LAST) ? '0 : vcnt_r + VW'(1);
            end else begin
               vcnt_r <= vcnt_r;
            end
            // pix_r is the address of the next visible pixel; rd_addr_o only ever takes visible addresses
            if (frame_end_s) begin
               pix_r     <= '0;
               rd_addr_o <= '0;
            end else if (active_s) begin
               pix_r     <= pix_r + ADDR_WIDTH'(1);
               rd_addr_o <= pix_r;
            end else begin
               pix_r     <= pix_r;
               rd_addr_o <= rd_addr_o;
            end
            act_d_r  <= active_s;
            hs_d_r   <= hsync_s;
            vs_d_r   <= vsync_s;
            rgb_o    <= act_d_r ? pal(rd_data_i) : 12'h000;
            hsync_o  <= hs_d_r;
            vsync_o  <= vs_d_r;
            vblank_o <= h_wrap_s && (vcnt_r == V_VIS_LAST);
         end else begin
            div_r <= div_r + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a reduced raster; outputs are predicted every clock from
// the elapsed clock count since reset release and a RAM image held in the bench.
module tb_vga_frame_reader;

   localparam int DIV = 4;
   localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
   localparam int VV = 6,  VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int NPIX = HV * VV;
   localparam logic [33:0] RST_V = {19'd0, 1'b1, 1'b1, 12'h000, 1'b0};

   typedef struct {
      logic [7:0]  code;
      logic [11:0] rgb;
   } pal_vec_t;

   logic        clk;
   logic        rst_n;
   logic [18:0] rd_addr;
   logic [7:0]  rd_data;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic        vblank;

   logic [7:0]  mem [NPIX];
   logic [11:0] pal_ref [4];
   int          c;
   int          errors;
   int          checks;
   int          vb_cnt;

   vga_frame_reader #(
      .ADDR_WIDTH(19), .DATA_WIDTH(8), .CLK_DIV(DIV),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
      .hsync_o(hsync), .vsync_o(vsync), .rgb_o(rgb), .vblank_o(vblank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clocks elapsed since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) c <= 0;
      else        c <= c + 1;
   end

   // Frame-buffer RAM with one clock of read latency
   always @(posedge clk) begin
      rd_data <= (int'(rd_addr) < NPIX) ? mem[int'(rd_addr)] : 8'hEE;
   end

   function automatic logic [11:0] ref_pal(input logic [7:0] code);
      return (code < 8'd4) ? pal_ref[code[1:0]] : 12'hF0F;
   endfunction

   // Last visible address issued at or before scan position p of a frame
   function automatic logic [18:0] addr_of(input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      if (p == FT - 1) return 19'd0;
      if (v >= VV)     return 19'(NPIX - 1);
      if (h >= HV)     return 19'(v * HV + HV - 1);
      return 19'(v * HV + h);
   endfunction

   function automatic logic [33:0] expect_at(input int cc);
      int n, k, p, q, hq, vq;
      logic hs, vs, vb;
      logic [11:0] col;
      n = cc / DIV;
      if (n == 0) return RST_V;
      k = n - 1;
      p = k % FT;
      if (k == 0) begin
         hs = 1'b1; vs = 1'b1; col = 12'h000;
      end else begin
         q  = (k - 1) % FT;
         hq = q % HT;
         vq = q / HT;
         hs = !(hq >= HV + HF && hq < HV + HF + HS);
         vs = !(vq >= VV + VF && vq < VV + VF + VS);
         col = (hq < HV && vq < VV) ? ref_pal(mem[vq * HV + hq]) : 12'h000;
      end
      vb = (cc % DIV == 0) && (p % HT == HT - 1) && (p / HT == VV - 1);
      return {addr_of(p), hs, vs, col, vb};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s c=%0d got=%h exp=%h", name, c, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (vblank) vb_cnt++;
      check("cycle", 64'({rd_addr, hsync, vsync, rgb, vblank}), 64'(rst_n ? expect_at(c) : RST_V));
   endtask

   initial begin
      pal_vec_t tab [8];
      int len, hi, r;
      tab[0] = '{8'h00, 12'h000};
      tab[1] = '{8'h01, 12'hDB6};
      tab[2] = '{8'h02, 12'h888};
      tab[3] = '{8'h03, 12'h04F};
      tab[4] = '{8'h07, 12'hF0F};
      tab[5] = '{8'h04, 12'hF0F};
      tab[6] = '{8'h81, 12'hF0F};
      tab[7] = '{8'hFF, 12'hF0F};
      pal_ref[0] = 12'h000; pal_ref[1] = 12'hDB6; pal_ref[2] = 12'h888; pal_ref[3] = 12'h04F;
      errors = 0; checks = 0; vb_cnt = 0;

      rst_n = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         r = $urandom_range(0, 6);
         mem[i] = (r < 5) ? 8'(r) : 8'($urandom_range(4, 255));
      end
      repeat (5) step();
      rst_n = 1'b1;

      // Horizontal sync width and period
      for (int i = 0; i < 400 && hsync; i++) step();
      len = 0;
      while (!hsync && len < 400) begin step(); len++; end
      hi = 0;
      while (hsync && hi < 400) begin step(); hi++; end
      check("hsync_low", 64'(len), 64'(HS * DIV));
      check("hsync_period", 64'(len + hi), 64'(HT * DIV));

      // Vertical sync width and frame period
      for (int i = 0; i < FT * DIV + 10 && vsync; i++) step();
      len = 0;
      while (!vsync && len < FT * DIV) begin step(); len++; end
      hi = 0;
      while (vsync && hi < FT * DIV + 10) begin step(); hi++; end
      check("vsync_low", 64'(len), 64'(VS * HT * DIV));
      check("frame_period", 64'(len + hi), 64'(FT * DIV));

      vb_cnt = 0;
      repeat (2 * FT * DIV) step();
      check("vblank_2frames", 64'(vb_cnt), 64'd2);

      // Reset mid-frame on row 3, then one clean frame
      for (int i = 0; i < FT * DIV + 10 && ((c / DIV) % FT != 3 * HT + 5); i++) step();
      check("reached_row3", 64'((c / DIV) % FT), 64'(3 * HT + 5));
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'({rd_addr, hsync, vsync, rgb, vblank}), 64'(RST_V));
      step();
      rst_n = 1'b1;
      vb_cnt = 0;
      repeat (FT * DIV) step();
      check("vblank_after_rst", 64'(vb_cnt), 64'd1);

      // Palette table: uniform RAM per code, visible pixel then horizontal blanking
      for (int t = 0; t < 8; t++) begin
         rst_n = 1'b0;
         for (int i = 0; i < NPIX; i++) mem[i] = tab[t].code;
         step();
         rst_n = 1'b1;
         repeat (12) step();
         check("pal_visible", 64'(rgb), 64'(tab[t].rgb));
         repeat (88 - 12) step();
         check("pal_blank", 64'(rgb), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
